// File: rtl/even_seq_checker.sv
// even_seq_checker: checks an even 0..MAX_VAL sequence, reports lock, error pulses and a saturating error count; define EVEN_SEQ_CHK_STICKY_EN to add clr_sticky/err_sticky
module even_seq_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W = 8,
  parameter int MAX_VAL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [0:3]       seq_in,
`ifdef EVEN_SEQ_CHK_STICKY_EN
  input  logic             clr_sticky,
  output logic             err_sticky,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [0:3]       last_val
);
  localparam logic [1:0] HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2;
  logic [1:0] state, nxt_state;
  logic [3:0] match_cnt, cnt_inc, nxt_cnt;
  logic [0:3] expected;
  logic legal, match, err;
  // Classify the current sample and work out where the FSM goes next
  always_comb begin
    legal = !seq_in[3] && seq_in <= 4'(MAX_VAL);
    expected = last_val == 4'(MAX_VAL) ? 4'd0 : last_val + 4'd2;
    match = legal && seq_in == expected;
    err = en && (!legal || (state == LOCKED && !match));
    cnt_inc = match_cnt + 4'd1;
    nxt_state = !legal ? HUNT :
                (match && state != HUNT) ? ((state == LOCKED || cnt_inc == 4'(LOCK_COUNT)) ? LOCKED : CONFIRM) :
                CONFIRM;
    nxt_cnt = (state == CONFIRM && match) ? cnt_inc : 4'd0;
  end
  // FSM, lock flag, last legal sample and saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
      match_cnt <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      last_val <= '0;
    end else begin
      err_pulse <= err;
      if (en) begin
        state <= nxt_state;
        match_cnt <= nxt_cnt;
        locked <= nxt_state == LOCKED;
        last_val <= legal ? seq_in : last_val;
        err_count <= (err && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
      end
    end
  end
`ifdef EVEN_SEQ_CHK_STICKY_EN
  // Sticky error flag; a new error outranks a clear request
  always_ff @(posedge clk) begin
    if (reset) err_sticky <= 1'b0;
    else err_sticky <= err ? 1'b1 : clr_sticky ? 1'b0 : err_sticky;
  end
`endif
endmodule
